rf_writeback_arbiter: RTL and testbench

//   Writer side of the register-file write port (RegWrite / RD_Address / RDdata).

---
 rtl/rf_writeback_arbiter_pkg.sv | 16 +
 rtl/rf_writeback_arbiter_if.sv | 59 +++++
 rtl/rf_writeback_arbiter_fifo.sv | 100 ++++++++++
 rtl/rf_writeback_arbiter.sv | 135 +++++++++++++
 tb/tb_rf_writeback_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared register-file writeback types and constants (package rf_pkg).
// Optional bypass lookup is enabled by defining RF_WB_BYPASS_EN.
package rf_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;
    localparam int RF_DEPTH = 4;
    localparam logic [RF_AW-1:0] REG_ZERO = 5'd0;

    // One pending register-file write: destination and result.
    typedef struct packed {
        logic [RF_AW-1:0] rd;
        logic [RF_DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Bundle of result-producer inputs and RF write-port outputs of the writeback arbiter.
// Bypass query signals exist only when RF_WB_BYPASS_EN is defined.
//
// Handshake: the long-latency source offers a result with lu_valid; the result is
// transferred on a rising edge where lu_valid && lu_ready. lu_ready depends only on
// registered occupancy, never on lu_valid or on a same-cycle pop. The ALU source has
// no backpressure: alu_valid means "take it this edge".
interface rf_writeback_arbiter_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [DW-1:0]   alu_data;
    logic            lu_valid;
    logic            lu_ready;
    logic [AW-1:0]   lu_rd;
    logic [DW-1:0]   lu_data;
    logic            RegWrite;
    logic [AW-1:0]   RD_Address;
    logic [DW-1:0]   RDdata;
    logic [2**AW-1:0] pending;
    logic [CW-1:0]   qcount;
`ifdef RF_WB_BYPASS_EN
    logic [AW-1:0]   byp_addr;
    logic            byp_hit;
    logic [DW-1:0]   byp_data;
`endif

    // Producer / hazard-unit side.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lu_valid, lu_rd, lu_data,
        input  lu_ready,
        input  RegWrite, RD_Address, RDdata,
        input  pending, qcount
`ifdef RF_WB_BYPASS_EN
        , output byp_addr
        , input  byp_hit, byp_data
`endif
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lu_valid, lu_rd, lu_data,
        output lu_ready,
        output RegWrite, RD_Address, RDdata,
        output pending, qcount
`ifdef RF_WB_BYPASS_EN
        , input  byp_addr
        , output byp_hit, byp_data
`endif
    );

endinterface

// File: rtl/rf_writeback_arbiter_fifo.sv
// In-order FIFO of long-latency writeback requests (module wb_fifo).
// Exposes per-entry valid bits and destinations for the pending scoreboard; with
// RF_WB_BYPASS_EN defined it also exposes entry data and the head pointer.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  wb_req_t                     req_i,
    input  logic                        pop_i,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [CW-1:0]               count_o,
    output wb_req_t                     head_o,
    output logic [DEPTH-1:0]            valid_o,
    output logic [DEPTH-1:0][RF_AW-1:0] entry_rd_o
`ifdef RF_WB_BYPASS_EN
    , output logic [DEPTH-1:0][RF_DW-1:0] entry_data_o
    , output logic [PW-1:0]               rd_ptr_o
`endif
);

    wb_req_t [DEPTH-1:0] mem_q;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic                do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = valid_q;

    // Pointer, occupancy and valid-bit next state; DEPTH is a power of 2 so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (do_pop) begin
            rd_ptr_d          = rd_ptr_q + PW'(1);
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (do_push) begin
            wr_ptr_d          = wr_ptr_q + PW'(1);
            valid_d[wr_ptr_q] = 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Entry storage; contents are meaningless unless the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= req_i;
        end
    end

    // Flatten entry destinations (and data, when bypass is built) for the top level.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_rd_o[i] = mem_q[i].rd;
`ifdef RF_WB_BYPASS_EN
            entry_data_o[i] = mem_q[i].data;
`endif
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign rd_ptr_o = rd_ptr_q;
`endif

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter: ALU results win the single RF write port every cycle,
// long-latency results queue in a FIFO and drain when the ALU is idle.
// Defining RF_WB_BYPASS_EN adds a combinational forwarding lookup (byp_addr/byp_hit/byp_data).
// DW/AW must match RF_DW/RF_AW of rf_pkg since queued entries use wb_req_t.
module rf_writeback_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    parameter int DW    = RF_DW,
    parameter int AW    = RF_AW
) (
    input  logic               clk,
    input  logic               rst,
    rf_writeback_arbiter_if.slave wb
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic                        alu_win;
    logic                        lu_push;
    logic                        fifo_pop;
    logic                        fifo_full, fifo_empty;
    logic [CW-1:0]               fifo_count;
    wb_req_t                     fifo_head;
    wb_req_t                     lu_req;
    logic [DEPTH-1:0]            fifo_valid;
    logic [DEPTH-1:0][RF_AW-1:0] fifo_rd;
    logic [2**AW-1:0]            pending_c;

    logic                        regwrite_q, regwrite_d;
    logic [AW-1:0]               rd_q, rd_d;
    logic [DW-1:0]               data_q, data_d;

    // A zero-destination ALU result is discarded and leaves the port free for the FIFO.
    assign alu_win  = wb.alu_valid && (wb.alu_rd != REG_ZERO);
    // A zero-destination LU result still handshakes but never enters the queue.
    assign lu_push  = wb.lu_valid && !fifo_full && (wb.lu_rd != REG_ZERO);
    assign fifo_pop = !alu_win && !fifo_empty;
    assign lu_req   = '{rd: wb.lu_rd, data: wb.lu_data};

`ifdef RF_WB_BYPASS_EN
    logic [DEPTH-1:0][RF_DW-1:0] fifo_data;
    logic [PW-1:0]               fifo_rd_ptr;
    logic [PW-1:0]               byp_idx;
`endif

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (lu_push),
        .req_i      (lu_req),
        .pop_i      (fifo_pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .head_o     (fifo_head),
        .valid_o    (fifo_valid),
        .entry_rd_o (fifo_rd)
`ifdef RF_WB_BYPASS_EN
        , .entry_data_o (fifo_data)
        , .rd_ptr_o     (fifo_rd_ptr)
`endif
    );

    // Priority mux for the output register: ALU, then FIFO head, else idle with address/data held.
    always_comb begin
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        data_d     = data_q;
        if (alu_win) begin
            regwrite_d = 1'b1;
            rd_d       = wb.alu_rd;
            data_d     = wb.alu_data;
        end else if (!fifo_empty) begin
            regwrite_d = 1'b1;
            rd_d       = fifo_head.rd;
            data_d     = fifo_head.data;
        end
    end

    // RF write-port output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
        end
    end

    // Pending scoreboard: OR of all queued destinations, so duplicates hold the bit until the last pops.
    always_comb begin
        pending_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i]) begin
                pending_c[fifo_rd[i]] = 1'b1;
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    // Forwarding lookup: walk the queue oldest to youngest so the youngest match wins,
    // then let the output register override.
    always_comb begin
        wb.byp_hit  = 1'b0;
        wb.byp_data = '0;
        byp_idx     = '0;
        if (wb.byp_addr != REG_ZERO) begin
            for (int i = 0; i < DEPTH; i++) begin
                byp_idx = fifo_rd_ptr + PW'(i);
                if (fifo_valid[byp_idx] && (fifo_rd[byp_idx] == wb.byp_addr)) begin
                    wb.byp_hit  = 1'b1;
                    wb.byp_data = fifo_data[byp_idx];
                end
            end
            if (regwrite_q && (rd_q == wb.byp_addr)) begin
                wb.byp_hit  = 1'b1;
                wb.byp_data = data_q;
            end
        end
    end
`endif

    assign wb.lu_ready   = !fifo_full;
    assign wb.RegWrite   = regwrite_q;
    assign wb.RD_Address = rd_q;
    assign wb.RDdata     = data_q;
    assign wb.pending    = pending_c;
    assign wb.qcount     = fifo_count;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed self-checking bench for rf_writeback_arbiter (DEPTH=4, DW=32, AW=5).
// The bypass scenario is compiled only when RF_WB_BYPASS_EN is defined.
module tb_rf_writeback_arbiter;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    // Expected LU writes in issue order: {rd, data}.
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] exp_e;
    int               exp_qc[5];

    rf_writeback_arbiter_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) wb_if ();

    rf_writeback_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb_if)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        wb_if.alu_valid = v;
        wb_if.alu_rd    = rd;
        wb_if.alu_data  = d;
    endtask

    task automatic drive_lu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        wb_if.lu_valid = v;
        wb_if.lu_rd    = rd;
        wb_if.lu_data  = d;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [AW-1:0] rd,
                            input logic [DW-1:0] d);
        check_eq(tag, {27'd0, wb_if.RegWrite, wb_if.RD_Address, wb_if.RDdata}, {27'd0, we, rd, d});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive_alu(1'b0, '0, '0);
        drive_lu(1'b0, '0, '0);
`ifdef RF_WB_BYPASS_EN
        wb_if.byp_addr = '0;
`endif
        step();
        step();
        rst = 1'b0;

        // Reset state.
        check_wr("rst_port", 1'b0, 5'd0, 32'd0);
        check_eq("rst_qcount", 64'(wb_if.qcount), 64'd0);
        check_eq("rst_pending", 64'(wb_if.pending), 64'd0);
        check_eq("rst_ready", 64'(wb_if.lu_ready), 64'd1);

        // 1. Single ALU write, one cycle latency.
        drive_alu(1'b1, 5'd3, 32'hAA);
        step();
        check_wr("t1_alu_wr", 1'b1, 5'd3, 32'hAA);
        drive_alu(1'b0, '0, '0);
        step();
        check_wr("t1_idle_hold", 1'b0, 5'd3, 32'hAA);

        // 2. Single LU write: two-cycle latency, pending for one cycle.
        drive_lu(1'b1, 5'd7, 32'h1234);
        check_eq("t2_ready", 64'(wb_if.lu_ready), 64'd1);
        step();
        drive_lu(1'b0, '0, '0);
        check_eq("t2_no_wr_yet", 64'(wb_if.RegWrite), 64'd0);
        check_eq("t2_qcount1", 64'(wb_if.qcount), 64'd1);
        check_eq("t2_pending7", 64'(wb_if.pending), 64'h80);
        step();
        check_wr("t2_lu_wr", 1'b1, 5'd7, 32'h1234);
        check_eq("t2_pending_clr", 64'(wb_if.pending), 64'd0);
        check_eq("t2_qcount0", 64'(wb_if.qcount), 64'd0);
        step();
        check_eq("t2_idle", 64'(wb_if.RegWrite), 64'd0);

        // 3. ALU every cycle starves the FIFO; lu_ready drops after 4 accepts.
        for (int i = 0; i < 6; i++) begin
            drive_alu(1'b1, 5'(i + 1), 32'h100 + 32'(i));
            if (i < 4) drive_lu(1'b1, 5'(10 + i), 32'h2000 + 32'(i));
            else       drive_lu(1'b1, 5'd14, 32'h2004);
            check_eq($sformatf("t3_ready_%0d", i), 64'(wb_if.lu_ready), (i < 4) ? 64'd1 : 64'd0);
            if (i < 4) exp_q.push_back({5'(10 + i), 32'h2000 + 32'(i)});
            step();
            check_wr($sformatf("t3_alu_wr_%0d", i), 1'b1, 5'(i + 1), 32'h100 + 32'(i));
        end
        check_eq("t3_qcount_full", 64'(wb_if.qcount), 64'd4);
        check_eq("t3_pending_full", 64'(wb_if.pending), 64'h3C00);

        // Drain: first cycle full (no accept even though a pop happens), second cycle push+pop.
        exp_qc = '{3, 3, 2, 1, 0};
        for (int j = 0; j < 5; j++) begin
            drive_alu(1'b0, '0, '0);
            if (j < 2) drive_lu(1'b1, 5'd14, 32'h2004);
            else       drive_lu(1'b0, '0, '0);
            check_eq($sformatf("t3_drain_ready_%0d", j), 64'(wb_if.lu_ready), (j == 0) ? 64'd0 : 64'd1);
            if (j == 1) exp_q.push_back({5'd14, 32'h2004});
            step();
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL t3_scoreboard_empty at drain %0d", j);
            end else begin
                exp_e = exp_q.pop_front();
                check_wr($sformatf("t3_lu_wr_%0d", j), 1'b1, exp_e[AW+DW-1:DW], exp_e[DW-1:0]);
            end
            check_eq($sformatf("t3_qcount_%0d", j), 64'(wb_if.qcount), 64'(exp_qc[j]));
        end
        drive_lu(1'b0, '0, '0);
        check_eq("t3_pending_end", 64'(wb_if.pending), 64'd0);
        step();
        check_wr("t3_idle_hold", 1'b0, 5'd14, 32'h2004);

        // 4. Zero destination from both sources.
        drive_alu(1'b1, 5'd0, 32'h55);
        drive_lu(1'b1, 5'd0, 32'h66);
        check_eq("t4_ready", 64'(wb_if.lu_ready), 64'd1);
        step();
        drive_alu(1'b0, '0, '0);
        drive_lu(1'b0, '0, '0);
        check_wr("t4_no_wr", 1'b0, 5'd14, 32'h2004);
        check_eq("t4_qcount", 64'(wb_if.qcount), 64'd0);
        check_eq("t4_pending", 64'(wb_if.pending), 64'd0);
        step();
        check_eq("t4_no_wr2", 64'(wb_if.RegWrite), 64'd0);

        // 5. Reset mid-operation discards three queued entries.
        for (int k = 0; k < 3; k++) begin
            drive_alu(1'b1, 5'd2, 32'h77);
            drive_lu(1'b1, 5'(20 + k), 32'h300 + 32'(k));
            step();
        end
        check_eq("t5_qcount3", 64'(wb_if.qcount), 64'd3);
        check_eq("t5_pending3", 64'(wb_if.pending), 64'h700000);
        rst = 1'b1;
        drive_alu(1'b1, 5'd4, 32'h99);
        drive_lu(1'b1, 5'd25, 32'h400);
        step();
        rst = 1'b0;
        drive_alu(1'b0, '0, '0);
        drive_lu(1'b0, '0, '0);
        check_wr("t5_rst_port", 1'b0, 5'd0, 32'd0);
        check_eq("t5_rst_qcount", 64'(wb_if.qcount), 64'd0);
        check_eq("t5_rst_pending", 64'(wb_if.pending), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_wr($sformatf("t5_no_wr_%0d", k), 1'b0, 5'd0, 32'd0);
        end

`ifdef RF_WB_BYPASS_EN
        // 6. Bypass: youngest queued match wins; register 0 never hits; output register checked.
        drive_alu(1'b1, 5'd2, 32'h5);
        drive_lu(1'b1, 5'd9, 32'h11);
        step();
        drive_lu(1'b1, 5'd9, 32'h22);
        step();
        drive_lu(1'b0, '0, '0);
        wb_if.byp_addr = 5'd9;
        #1;
        check_eq("t6_hit9", 64'(wb_if.byp_hit), 64'd1);
        check_eq("t6_data9", 64'(wb_if.byp_data), 64'h22);
        wb_if.byp_addr = 5'd0;
        #1;
        check_eq("t6_hit0", 64'(wb_if.byp_hit), 64'd0);
        check_eq("t6_data0", 64'(wb_if.byp_data), 64'd0);
        wb_if.byp_addr = 5'd2;
        #1;
        check_eq("t6_hit_outreg", 64'(wb_if.byp_hit), 64'd1);
        check_eq("t6_data_outreg", 64'(wb_if.byp_data), 64'h5);
        wb_if.byp_addr = 5'd0;
        drive_alu(1'b0, '0, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
